// File: rtl/cell_painter.sv
// cell_painter: turns queued cell paint requests into per-pixel writes
// for vga_adapter, one cell rasterised at a time from a 4-deep FIFO.
module cell_painter #(
    parameter int CELL_SIZE = 8,
    parameter int X_ORIGIN  = 16,
    parameter int Y_ORIGIN  = 8,
    parameter int GRID_DIM  = 14
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_col,
    input  logic [3:0] req_row,
    input  logic [2:0] req_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       req_error
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, FINISH} state_t;

    localparam logic [2:0] LAST = 3'(CELL_SIZE - 1);

    state_t      state_q, state_d;
    logic [10:0] mem_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [10:0] ent_q, ent_d;
    logic [7:0]  base_x_q, base_x_d;
    logic [6:0]  base_y_q, base_y_d;
    logic [2:0]  lat_colour_q, lat_colour_d;
    logic [2:0]  dx_q, dx_d;
    logic [2:0]  dy_q, dy_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic hs, in_range, push, pop;

    assign req_ready = (count_q != 3'd4);
    assign busy      = (state_q != IDLE) || (count_q != 3'd0);
    assign hs        = req_valid && req_ready;
    assign in_range  = ({1'b0, req_col} < 5'(GRID_DIM))
                    && ({1'b0, req_row} < 5'(GRID_DIM));
    assign push      = hs && in_range;
    assign pop       = (state_q == IDLE) && (count_q != 3'd0);

    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign done      = done_q;
    assign req_error = err_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != 3'd0) state_d = LOAD;
            LOAD:    state_d = DRAW;
            DRAW:    if (dx_q == LAST && dy_q == LAST) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + 2'(push);
        rd_ptr_d     = rd_ptr_q + 2'(pop);
        count_d      = count_q;
        if (push && !pop)      count_d = count_q + 3'd1;
        else if (!push && pop) count_d = count_q - 3'd1;
        ent_d        = ent_q;
        base_x_d     = base_x_q;
        base_y_d     = base_y_q;
        lat_colour_d = lat_colour_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = hs && !in_range;
        case (state_q)
            IDLE: begin
                if (pop) ent_d = mem_q[rd_ptr_q];
            end
            LOAD: begin
                // 9-bit sums, truncated to the vga_adapter coordinate widths
                base_x_d = 8'(9'(X_ORIGIN)
                         + 9'(ent_q[10:7]) * 9'(CELL_SIZE));
                base_y_d = 7'(9'(Y_ORIGIN)
                         + 9'(ent_q[6:3]) * 9'(CELL_SIZE));
                lat_colour_d = ent_q[2:0];
                dx_d = 3'd0;
                dy_d = 3'd0;
            end
            DRAW: begin
                x_d      = base_x_q + 8'(dx_q);
                y_d      = base_y_q + 7'(dy_q);
                colour_d = lat_colour_q;
                plot_d   = 1'b1;
                if (dx_q == LAST) begin
                    dx_d = 3'd0;
                    dy_d = dy_q + 3'd1;
                end else begin
                    dx_d = dx_q + 3'd1;
                end
            end
            FINISH: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wr_ptr_q] <= {req_col, req_row, req_colour};
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ent_q        <= '0;
            base_x_q     <= '0;
            base_y_q     <= '0;
            lat_colour_q <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ent_q        <= ent_d;
            base_x_q     <= base_x_d;
            base_y_q     <= base_y_d;
            lat_colour_q <= lat_colour_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: doc/cell_painter.md
CELL_PAINTER -- requirements
Module: cell_painter

Interface
REQ-001 Parameter CELL_SIZE, default 8, meaning: cell edge in pixels; power of two, 2..8.
REQ-002 Parameter X_ORIGIN, default 16, meaning: screen x of the grid's left edge.
REQ-003 Parameter Y_ORIGIN, default 8, meaning: screen y of the grid's top edge.
REQ-004 Parameter GRID_DIM, default 14, meaning: cells per row and per column.
REQ-005 The ports SHALL be, one per line, as follows.
- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  a paint request is present.
- req_ready  out  1  request FIFO can accept.
- req_col  in  4  cell column.
- req_row  in  4  cell row.
- req_colour  in  3  RGB colour for the cell.
- x  out  8  pixel x to vga_adapter.
- y  out  7  pixel y to vga_adapter.
- colour  out  3  pixel colour to vga_adapter.
- plot  out  1  pixel write enable to vga_adapter.
- busy  out  1  work queued or in progress.
- done  out  1  one-cycle pulse per completed cell.
- req_error  out  1  one-cycle pulse per rejected request.

Function
REQ-006 The block SHALL sit between the game datapath and vga_adapter, converting cell paint requests into per-pixel writes.
REQ-007 A handshake SHALL occur on a rising edge where req_valid=1 and req_ready=1; req_ready SHALL equal FIFO not full.
REQ-008 A handshake with req_col>=GRID_DIM or req_row>=GRID_DIM SHALL be dropped and SHALL pulse req_error on the next cycle.
REQ-009 An in-range handshake SHALL push {col,row,colour} into a 4-entry FIFO, preserving order.
REQ-010 Simultaneous push and pop SHALL both occur and leave the FIFO count unchanged.
REQ-011 The FSM SHALL have states IDLE, LOAD, DRAW, FINISH.
REQ-012 In IDLE with FIFO non-empty, the FSM SHALL pop one entry and go to LOAD; otherwise it stays in IDLE.
REQ-013 LOAD SHALL latch base_x=X_ORIGIN+col*CELL_SIZE, base_y=Y_ORIGIN+row*CELL_SIZE and the colour, clear dx and dy, then go to DRAW.
REQ-014 Base arithmetic SHALL be computed at 9 bits and truncated to 8 bits (x) or 7 bits (y); the defaults never overflow.
REQ-015 DRAW SHALL emit one pixel per cycle as registered outputs: x=base_x+dx, y=base_y+dy, the latched colour, and plot=1.
REQ-016 Pixels SHALL be emitted in raster order: dx increments each pixel; on dx=CELL_SIZE-1, dx wraps to 0 and dy increments.
REQ-017 After pixel (CELL_SIZE-1, CELL_SIZE-1), the FSM SHALL go to FINISH, which drives plot=0 and done=1 for one cycle and then returns to IDLE.
REQ-018 plot SHALL be 1 on exactly CELL_SIZE*CELL_SIZE consecutive cycles per cell, with no gaps.
REQ-019 The first plot=1 SHALL appear on the third rising edge after the accepting edge when the FSM is IDLE and the FIFO is empty.
REQ-020 busy SHALL be 1 whenever the state is not IDLE or the FIFO is non-empty.
REQ-021 Requests SHALL keep being accepted during DRAW; the input side never stalls the pixel stream.

Reset
REQ-022 While reset=1 on a clock edge, the block SHALL:
- go to IDLE and empty the FIFO;
- clear dx, dy and the latched values;
- drive x=0, y=0, colour=0, plot=0, busy=0, done=0, req_error=0, req_ready=1 on the next cycle.
REQ-023 A reset mid-DRAW SHALL abandon the cell with no done pulse; any request presented in the reset cycle SHALL be ignored.

Verification
REQ-024 Single request: col=0, row=0, colour=3'b100 into an idle block ->
- plot high for 64 cycles starting on the 3rd edge after the accepting edge;
- x 16..23, y 8..15 in raster order, colour=3'b100;
- done pulses once, then busy=0.
REQ-025 Corner cell: col=13, row=13 -> x 120..127, y 112..119; last pixel (127,119).
REQ-026 Out of range: col=14, row=0 -> req_error=1 for one cycle; no plot; busy stays 0.
REQ-027 Backpressure: hold req_valid=1 with 6 distinct cells ->
- req_ready falls once 4 entries are queued;
- all 6 cells are drawn in order;
- 6 done pulses occur and no request is lost or duplicated.
REQ-028 Reset mid-draw: assert reset at the 20th pixel of a cell with 2 entries queued -> next cycle plot=0, busy=0, req_ready=1; no done pulse; queued cells are never drawn.
